// File: rtl/ffs_decode_m.sv
// Purpose : accumulates a frame of bit-index beats into a one-hot OR mask plus a population count.
// Latency : the mask is presented (out_valid) on the cycle after the in_last beat is accepted.
// Backpr. : no beats are accepted while a mask is held; the mask stays put until out_ready.
//
// Ports:
//   clk, rst               - rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready      - index beat handshake; in_index = bit to set, in_last = closes frame
//   out_valid/out_ready    - completed mask handshake
//   out_mask, out_count    - registered OR of the frame's one-hot decodes and its set-bit count
//   out_err                - (only with FFS_DECODE_RANGE_CHECK_EN) frame saw an index >= OUTPUT_WIDTH
//
// Optional feature macro: FFS_DECODE_RANGE_CHECK_EN
module ffs_decode_m #(
   parameter int OUTPUT_WIDTH = 8,
   // Widths below 1 are clamped to 1.
   localparam int MASK_WIDTH  = (OUTPUT_WIDTH < 1) ? 1 : OUTPUT_WIDTH,
   localparam int INDEX_WIDTH = $clog2((MASK_WIDTH < 2) ? 2 : MASK_WIDTH),
   localparam int COUNT_WIDTH = $clog2(MASK_WIDTH + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [INDEX_WIDTH-1:0] in_index,
   input  logic                   in_last,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [MASK_WIDTH-1:0]  out_mask,
`ifdef FFS_DECODE_RANGE_CHECK_EN
   output logic                   out_err,
`endif
   output logic [COUNT_WIDTH-1:0] out_count
);

   if (OUTPUT_WIDTH < 1) begin : g_width_warn
      $warning("ffs_decode_m: OUTPUT_WIDTH < 1, treated as 1");
   end

   typedef enum logic {ACCUM, HOLD} state_t;

   state_t                 state;
   logic                   in_ready_r;
   logic                   out_valid_r;
   logic [MASK_WIDTH-1:0]  acc;
   logic [COUNT_WIDTH-1:0] cnt;

   logic                   accept;
   logic                   in_range;
   logic [MASK_WIDTH-1:0]  decode;
   logic                   is_new;

   assign accept   = in_valid & in_ready_r;
   // Indices past the mask only exist for non-power-of-two widths; they decode to nothing.
   assign in_range = (32'(in_index) < MASK_WIDTH);
   assign decode   = in_range ? (MASK_WIDTH'(1) << in_index) : '0;
   // Count only bits that were clear, so duplicate indices leave the count alone.
   assign is_new   = |(decode & ~acc);

`ifdef FFS_DECODE_RANGE_CHECK_EN
   logic err;
   assign out_err = err;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ACCUM;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         acc         <= '0;
         cnt         <= '0;
`ifdef FFS_DECODE_RANGE_CHECK_EN
         err         <= 1'b0;
`endif
      end else begin
         case (state)
            ACCUM: begin
               if (accept) begin
                  acc <= acc | decode;
                  if (is_new) begin
                     cnt <= cnt + COUNT_WIDTH'(1);
                  end
`ifdef FFS_DECODE_RANGE_CHECK_EN
                  if (!in_range) begin
                     err <= 1'b1;
                  end
`endif
                  if (in_last) begin
                     state       <= HOLD;
                     in_ready_r  <= 1'b0;
                     out_valid_r <= 1'b1;
                  end
               end
            end
            HOLD: begin
               // Hand-off and restart on the same edge keeps the frame period at 2 cycles.
               if (out_ready) begin
                  state       <= ACCUM;
                  in_ready_r  <= 1'b1;
                  out_valid_r <= 1'b0;
                  acc         <= '0;
                  cnt         <= '0;
`ifdef FFS_DECODE_RANGE_CHECK_EN
                  err         <= 1'b0;
`endif
               end
            end
            default: begin
               state       <= ACCUM;
               in_ready_r  <= 1'b1;
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign out_mask  = acc;
   assign out_count = cnt;

endmodule

// File: tb/tb_ffs_decode_m.sv
module tb_ffs_decode_m;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // 8-bit instance
   logic       v8 = 0, l8 = 0, or8 = 0, ir8, ov8;
   logic [2:0] i8 = '0;
   logic [7:0] m8;
   logic [3:0] c8;
   // 5-bit instance (non-power-of-two, exercises out-of-range indices)
   logic       v5 = 0, l5 = 0, or5 = 0, ir5, ov5;
   logic [2:0] i5 = '0;
   logic [4:0] m5;
   logic [2:0] c5;
`ifdef FFS_DECODE_RANGE_CHECK_EN
   logic       e8, e5;
`endif

   ffs_decode_m #(.OUTPUT_WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(v8), .in_ready(ir8), .in_index(i8), .in_last(l8),
      .out_valid(ov8), .out_ready(or8), .out_mask(m8),
`ifdef FFS_DECODE_RANGE_CHECK_EN
      .out_err(e8),
`endif
      .out_count(c8));

   ffs_decode_m #(.OUTPUT_WIDTH(5)) dut5 (
      .clk(clk), .rst(rst), .in_valid(v5), .in_ready(ir5), .in_index(i5), .in_last(l5),
      .out_valid(ov5), .out_ready(or5), .out_mask(m5),
`ifdef FFS_DECODE_RANGE_CHECK_EN
      .out_err(e5),
`endif
      .out_count(c5));

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk8(input string tag, input logic ir, input logic ov,
                       input logic [7:0] m, input logic [3:0] c);
      check({tag, ".in_ready"},  32'(ir8), 32'(ir));
      check({tag, ".out_valid"}, 32'(ov8), 32'(ov));
      check({tag, ".out_mask"},  32'(m8),  32'(m));
      check({tag, ".out_count"}, 32'(c8),  32'(c));
   endtask

   task automatic chk5(input string tag, input logic ov, input logic [4:0] m,
                       input logic [2:0] c, input logic e);
      check({tag, ".out_valid"}, 32'(ov5), 32'(ov));
      check({tag, ".out_mask"},  32'(m5),  32'(m));
      check({tag, ".out_count"}, 32'(c5),  32'(c));
`ifdef FFS_DECODE_RANGE_CHECK_EN
      check({tag, ".out_err"},   32'(e5),  32'(e));
`else
      if (e) begin end
`endif
   endtask

   // One record per cycle: inputs driven this cycle, outputs expected in this cycle.
   typedef struct {
      logic       v;
      logic [2:0] idx;
      logic       last;
      logic       ordy;
      logic       ir;
      logic       ov;
      logic [7:0] m;
      logic [3:0] c;
   } vec_t;

   vec_t tbl[22];

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not complete, time %0t", $time);
      $fatal(1, "timeout");
   end

   initial begin : main
      //            v  idx   last ordy  ir ov  mask   cnt
      // frame 1,3,6 (last on 6), consumer always ready
      tbl[0]  = '{1, 3'd1, 0, 1,   1, 0, 8'h00, 4'd0};
      tbl[1]  = '{1, 3'd3, 0, 1,   1, 0, 8'h02, 4'd1};
      tbl[2]  = '{1, 3'd6, 1, 1,   1, 0, 8'h0A, 4'd2};
      tbl[3]  = '{0, 3'd0, 0, 1,   0, 1, 8'h4A, 4'd3};
      tbl[4]  = '{0, 3'd0, 0, 1,   1, 0, 8'h00, 4'd0};
      // frame 2,2,2 (duplicates)
      tbl[5]  = '{1, 3'd2, 0, 1,   1, 0, 8'h00, 4'd0};
      tbl[6]  = '{1, 3'd2, 0, 1,   1, 0, 8'h04, 4'd1};
      tbl[7]  = '{1, 3'd2, 1, 1,   1, 0, 8'h04, 4'd1};
      tbl[8]  = '{0, 3'd0, 0, 1,   0, 1, 8'h04, 4'd1};
      // frame 0 (last), consumer stalls 5 cycles while beats are offered
      tbl[9]  = '{1, 3'd0, 1, 0,   1, 0, 8'h00, 4'd0};
      tbl[10] = '{1, 3'd5, 1, 0,   0, 1, 8'h01, 4'd1};
      tbl[11] = '{1, 3'd5, 1, 0,   0, 1, 8'h01, 4'd1};
      tbl[12] = '{1, 3'd5, 1, 0,   0, 1, 8'h01, 4'd1};
      tbl[13] = '{1, 3'd5, 1, 0,   0, 1, 8'h01, 4'd1};
      tbl[14] = '{1, 3'd5, 1, 0,   0, 1, 8'h01, 4'd1};
      tbl[15] = '{0, 3'd0, 0, 1,   0, 1, 8'h01, 4'd1};
      tbl[16] = '{0, 3'd0, 0, 1,   1, 0, 8'h00, 4'd0};
      // frame 7, idle gap, 7 again (last)
      tbl[17] = '{1, 3'd7, 0, 1,   1, 0, 8'h00, 4'd0};
      tbl[18] = '{0, 3'd3, 1, 1,   1, 0, 8'h80, 4'd1};
      tbl[19] = '{1, 3'd7, 1, 1,   1, 0, 8'h80, 4'd1};
      tbl[20] = '{0, 3'd0, 0, 1,   0, 1, 8'h80, 4'd1};
      tbl[21] = '{0, 3'd0, 0, 1,   1, 0, 8'h00, 4'd0};

      // Reset state
      tick();
      tick();
      chk8("reset8", 1'b0 | ir8, 1'b0, 8'h00, 4'd0);  // in_ready checked again after release
      check("reset8.in_ready_during_rst", 32'(ir8), 32'd1);
      chk5("reset5", 1'b0, 5'd0, 3'd0, 1'b0);
      rst = 1'b0;
      tick();
      chk8("post_reset8", 1'b1, 1'b0, 8'h00, 4'd0);

      // Table-driven vectors
      for (int k = 0; k < 22; k++) begin
         v8 = tbl[k].v; i8 = tbl[k].idx; l8 = tbl[k].last; or8 = tbl[k].ordy;
         chk8($sformatf("vec%0d", k), tbl[k].ir, tbl[k].ov, tbl[k].m, tbl[k].c);
         tick();
      end

      // Back-to-back single-beat frames: one mask every 2 cycles
      or8 = 1'b1;
      for (int k = 0; k < 8; k++) begin
         v8 = 1'b1; i8 = 3'(k); l8 = 1'b1;
         chk8($sformatf("b2b%0d.accum", k), 1'b1, 1'b0, 8'h00, 4'd0);
         tick();
         v8 = 1'b0;
         chk8($sformatf("b2b%0d.hold", k), 1'b0, 1'b1, 8'(1) << k, 4'd1);
         tick();
      end

      // Reset pulsed mid-frame after indices 5,7
      v8 = 1'b1; i8 = 3'd5; l8 = 1'b0; tick();
      i8 = 3'd7; tick();
      v8 = 1'b0;
      check("midrst.pre_mask", 32'(m8), 32'hA0);
      rst = 1'b1; #1;
      chk8("midrst.async", 1'b1, 1'b0, 8'h00, 4'd0);
      #2 rst = 1'b0;
      tick();
      v8 = 1'b1; i8 = 3'd1; l8 = 1'b1; tick();
      v8 = 1'b0;
      chk8("midrst.frame", 1'b0, 1'b1, 8'h02, 4'd1);
      tick();

      // Reset while holding a pending mask
      v8 = 1'b1; i8 = 3'd4; l8 = 1'b1; or8 = 1'b0; tick();
      v8 = 1'b0;
      chk8("holdrst.pending", 1'b0, 1'b1, 8'h10, 4'd1);
      rst = 1'b1; #1;
      chk8("holdrst.async", 1'b1, 1'b0, 8'h00, 4'd0);
      #2 rst = 1'b0;
      tick();
      chk8("holdrst.after", 1'b1, 1'b0, 8'h00, 4'd0);

      // 5-bit instance: indices 4,6,7(last)
      v5 = 1'b1; i5 = 3'd4; l5 = 1'b0; or5 = 1'b0; tick();
      i5 = 3'd6; tick();
      i5 = 3'd7; l5 = 1'b1; tick();
      v5 = 1'b0;
      chk5("w5.oor", 1'b1, 5'b10000, 3'd1, 1'b1);
      check("w5.in_ready_hold", 32'(ir5), 32'd0);
      or5 = 1'b1; tick();
      chk5("w5.cleared", 1'b0, 5'd0, 3'd0, 1'b0);
      // next frame: index 0 (last)
      v5 = 1'b1; i5 = 3'd0; l5 = 1'b1; or5 = 1'b0; tick();
      v5 = 1'b0;
      chk5("w5.idx0", 1'b1, 5'b00001, 3'd1, 1'b0);
      or5 = 1'b1; tick();
      // frame with only an out-of-range index still closes, empty mask
      v5 = 1'b1; i5 = 3'd5; l5 = 1'b1; or5 = 1'b0; tick();
      v5 = 1'b0;
      chk5("w5.empty", 1'b1, 5'd0, 3'd0, 1'b1);
      or5 = 1'b1; tick();
      chk5("w5.idle", 1'b0, 5'd0, 3'd0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
